processor_pipe: RTL and testbench

//  Two-stage (FETCH/EXECUTE) successor of the single-cycle core: parametrised data width and register count.

---
 rtl/proc_pkg.sv | 84 ++++++++
 rtl/alu.sv | 30 +++
 rtl/proc_decode.sv | 71 +++++++
 rtl/processor_pipe.sv | 137 +++++++++++++
 tb/tb_processor_pipe.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the two-stage core: opcodes, branch conditions,
// ALU operation codes, instruction field positions and the decoded control word.
package proc_pkg;

  localparam int INSTR_W = 18;
  localparam int OPC_MSB = 17;
  localparam int OPC_LSB = 14;
  localparam int RX_MSB  = 13;
  localparam int RX_LSB  = 11;
  localparam int RY_MSB  = 10;
  localparam int RY_LSB  = 8;

  typedef enum logic [3:0] {
    OP_ADDI  = 4'd0,
    OP_LDI   = 4'd1,
    OP_LUI   = 4'd2,
    OP_LOAD  = 4'd3,
    OP_STORE = 4'd4,
    OP_BR    = 4'd5,
    OP_ALU   = 4'd6,
    OP_CALL  = 4'd7,
    OP_RET   = 4'd8,
    OP_HALT  = 4'd9,
    OP_NOP   = 4'd10
  } opcode_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_GT     = 3'd5,
    COND_LE     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_kind_e;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SHL   = 4'd5;
  localparam logic [3:0] ALU_SHR   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  typedef struct packed {
    logic       reg_we;
    logic       wb_mem;
    logic       a_ry;
    logic       b_imm;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    br_kind_e   br;
    logic       halt;
    cond_e      cond;
    logic [2:0] rx;
    logic [2:0] ry;
  } ctrl_t;

  // Signed test of rx against zero, from its zero flag and sign bit.
  function automatic logic cond_met(cond_e c, logic zero, logic neg);
    case (c)
      COND_ALWAYS: cond_met = 1'b1;
      COND_EQ:     cond_met = zero;
      COND_NE:     cond_met = !zero;
      COND_LT:     cond_met = neg;
      COND_GE:     cond_met = !neg;
      COND_GT:     cond_met = !neg && !zero;
      COND_LE:     cond_met = neg || zero;
      default:     cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the core; operation codes come from proc_pkg.
module alu import proc_pkg::*; #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    y_o = a_i;
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SHL:   y_o = a_i << shamt;
      ALU_SHR:   y_o = a_i >> shamt;
      ALU_SRA:   y_o = $signed(a_i) >>> shamt;
      ALU_PASSB: y_o = b_i;
      default:   y_o = a_i;
    endcase
  end

endmodule

// File: rtl/proc_decode.sv
// Combinational instruction decoder: 18-bit instruction to control word plus
// the sign-extended immediate each opcode needs.
module proc_decode import proc_pkg::*; #(
  parameter int WORD_SIZE = 18
) (
  input  logic [INSTR_W-1:0]   instr_i,
  output ctrl_t                ctrl_o,
  output logic [WORD_SIZE-1:0] imm_o
);

  logic [WORD_SIZE-1:0] imm8;
  logic [WORD_SIZE-1:0] imm11;

  assign imm8  = {{(WORD_SIZE-8){instr_i[7]}}, instr_i[7:0]};
  assign imm11 = {{(WORD_SIZE-11){instr_i[10]}}, instr_i[10:0]};

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.rx     = instr_i[RX_MSB:RX_LSB];
    ctrl_o.ry     = instr_i[RY_MSB:RY_LSB];
    ctrl_o.cond   = cond_e'(instr_i[RY_MSB:RY_LSB]);
    ctrl_o.alu_op = ALU_ADD;
    ctrl_o.br     = BR_NONE;
    imm_o         = imm8;
    case (instr_i[OPC_MSB:OPC_LSB])
      OP_ADDI: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.a_ry   = 1'b1;
        ctrl_o.b_imm  = 1'b1;
      end
      OP_LDI: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.b_imm  = 1'b1;
        ctrl_o.alu_op = ALU_PASSB;
        imm_o         = imm11;
      end
      OP_LUI: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.b_imm  = 1'b1;
        ctrl_o.alu_op = ALU_PASSB;
        imm_o         = imm11 << 7;
      end
      OP_LOAD: begin
        ctrl_o.reg_we  = 1'b1;
        ctrl_o.wb_mem  = 1'b1;
        ctrl_o.a_ry    = 1'b1;
        ctrl_o.b_imm   = 1'b1;
        ctrl_o.mem_req = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.a_ry    = 1'b1;
        ctrl_o.b_imm   = 1'b1;
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
      end
      OP_BR:   ctrl_o.br = BR_COND;
      OP_ALU: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.alu_op = instr_i[3:0];
      end
      OP_CALL: begin
        ctrl_o.br = BR_CALL;
        imm_o     = imm11;
      end
      OP_RET:  ctrl_o.br   = BR_RET;
      OP_HALT: ctrl_o.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/processor_pipe.sv
// Two-stage FETCH/EXECUTE core with memory wait states, call/return through a
// link register, halt, and a single-bubble flush on taken control transfers.
module processor_pipe import proc_pkg::*; #(
  parameter int                  WORD_SIZE     = 18,
  parameter int                  ADDR_SIZE     = 18,
  parameter int                  REG_ADDR_BITS = 3,
  parameter logic [ADDR_SIZE-1:0] RESET_IP     = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ADDR_SIZE-1:0] code_addr,
  input  logic [INSTR_W-1:0]   code_word,
  output logic                 memory_req,
  output logic                 memory_write_enable,
  output logic [ADDR_SIZE-1:0] memory_addr,
  output logic [WORD_SIZE-1:0] memory_in,
  input  logic [WORD_SIZE-1:0] memory_out,
  input  logic                 memory_ready,
  output logic                 halted,
  output logic                 retire
);

  localparam int REG_COUNT = 2 ** REG_ADDR_BITS;
  localparam logic [ADDR_SIZE-1:0] IP_ONE = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] fetch_ip_q, fetch_ip_d;
  logic [ADDR_SIZE-1:0] ex_ip_q, ex_ip_d;
  logic [ADDR_SIZE-1:0] lr_q, lr_d;
  logic [INSTR_W-1:0]   ex_instr_q, ex_instr_d;
  logic                 ex_valid_q, ex_valid_d;
  logic                 halted_q, halted_d;
  logic [WORD_SIZE-1:0] regs_q [REG_COUNT];

  ctrl_t                ctrl;
  logic [WORD_SIZE-1:0] imm;
  logic [WORD_SIZE-1:0] rx_val, ry_val, alu_a, alu_b, alu_y, wr_data;
  logic [ADDR_SIZE-1:0] target;
  logic                 mem_op, stall, fire, taken, wr_en;

  proc_decode #(.WORD_SIZE(WORD_SIZE)) u_decode (
    .instr_i (ex_instr_q),
    .ctrl_o  (ctrl),
    .imm_o   (imm)
  );

  assign rx_val = regs_q[ctrl.rx[REG_ADDR_BITS-1:0]];
  assign ry_val = regs_q[ctrl.ry[REG_ADDR_BITS-1:0]];
  assign alu_a  = ctrl.a_ry  ? ry_val : rx_val;
  assign alu_b  = ctrl.b_imm ? imm    : ry_val;

  alu #(.WIDTH(WORD_SIZE)) u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (ctrl.alu_op),
    .y_o  (alu_y)
  );

  // A memory op in EX blocks the whole pipe until the bus reports completion.
  assign mem_op = ex_valid_q && ctrl.mem_req;
  assign stall  = mem_op && !memory_ready;
  assign fire   = ex_valid_q && !stall;

  always_comb begin
    taken = 1'b0;
    if (fire) begin
      case (ctrl.br)
        BR_COND: taken = cond_met(ctrl.cond, rx_val == '0, rx_val[WORD_SIZE-1]);
        BR_CALL: taken = 1'b1;
        BR_RET:  taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

  assign target  = (ctrl.br == BR_RET) ? lr_q : ex_ip_q + imm[ADDR_SIZE-1:0];
  assign wr_en   = fire && ctrl.reg_we;
  assign wr_data = ctrl.wb_mem ? memory_out : alu_y;

  always_comb begin
    fetch_ip_d = fetch_ip_q;
    ex_ip_d    = ex_ip_q;
    ex_instr_d = ex_instr_q;
    ex_valid_d = ex_valid_q;
    halted_d   = halted_q;
    lr_d       = lr_q;
    if (!stall && !halted_q) begin
      if (fire && ctrl.halt) begin
        halted_d   = 1'b1;
        ex_valid_d = 1'b0;
      end else if (taken) begin
        fetch_ip_d = target;
        ex_valid_d = 1'b0;
      end else begin
        ex_instr_d = code_word;
        ex_ip_d    = fetch_ip_q;
        ex_valid_d = 1'b1;
        fetch_ip_d = fetch_ip_q + IP_ONE;
      end
    end
    if (fire && ctrl.br == BR_CALL) lr_d = ex_ip_q + IP_ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_ip_q <= RESET_IP;
      ex_ip_q    <= '0;
      ex_instr_q <= '0;
      ex_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      lr_q       <= '0;
    end else begin
      fetch_ip_q <= fetch_ip_d;
      ex_ip_q    <= ex_ip_d;
      ex_instr_q <= ex_instr_d;
      ex_valid_q <= ex_valid_d;
      halted_q   <= halted_d;
      lr_q       <= lr_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[ctrl.rx[REG_ADDR_BITS-1:0]] <= wr_data;
    end
  end

  assign code_addr           = fetch_ip_q;
  assign memory_req          = mem_op;
  assign memory_write_enable = mem_op && ctrl.mem_we;
  assign memory_addr         = alu_y[ADDR_SIZE-1:0];
  assign memory_in           = rx_val;
  assign halted              = halted_q;
  assign retire              = fire;

endmodule

// File: tb/tb_processor_pipe.sv
// Directed bench for processor_pipe: small programs in a behavioural code ROM,
// hand-computed expectations checked with immediate assertions at each step.
module tb_processor_pipe;

  logic        clock;
  logic        reset;
  logic [17:0] code_addr;
  logic [17:0] code_word;
  logic        memory_req;
  logic        memory_write_enable;
  logic [17:0] memory_addr;
  logic [17:0] memory_in;
  logic [17:0] memory_out;
  logic        memory_ready;
  logic        halted;
  logic        retire;

  logic [17:0] rom [0:63];
  int testCount = 0;
  int failCount = 0;

  localparam logic [17:0] NOP_W = 18'h3C000;

  processor_pipe dut (
    .clock               (clock),
    .reset               (reset),
    .code_addr           (code_addr),
    .code_word           (code_word),
    .memory_req          (memory_req),
    .memory_write_enable (memory_write_enable),
    .memory_addr         (memory_addr),
    .memory_in           (memory_in),
    .memory_out          (memory_out),
    .memory_ready        (memory_ready),
    .halted              (halted),
    .retire              (retire)
  );

  assign code_word = rom[code_addr[5:0]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [17:0] encR(logic [3:0] op, logic [2:0] rx, logic [2:0] ry, logic [7:0] imm8);
    return {op, rx, ry, imm8};
  endfunction

  function automatic logic [17:0] encI(logic [3:0] op, logic [2:0] rx, logic [10:0] imm11);
    return {op, rx, imm11};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int edges);
    repeat (edges) @(negedge clock);
  endtask

  task automatic clearRom();
    for (int i = 0; i < 64; i++) rom[i] = NOP_W;
  endtask

  task automatic resetCore();
    reset        = 1'b1;
    memory_ready = 1'b0;
    memory_out   = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    memory_ready = 1'b0;
    memory_out   = '0;

    // Immediate load then add-immediate, back to back.
    clearRom();
    rom[0] = encI(4'd1, 3'd1, 11'd5);
    rom[1] = encR(4'd0, 3'd2, 3'd1, 8'd3);
    resetCore();
    checkOutput("rst_code_addr", 32'(code_addr), 32'd0);
    checkOutput("rst_retire", 32'(retire), 32'd0);
    checkOutput("rst_memory_req", 32'(memory_req), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    applyStimulus(1);
    checkOutput("t1_code_addr_1", 32'(code_addr), 32'd1);
    checkOutput("t1_retire_1", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t1_code_addr_2", 32'(code_addr), 32'd2);
    checkOutput("t1_retire_2", 32'(retire), 32'd1);
    checkOutput("t1_r1", 32'(dut.regs_q[1]), 32'd5);
    applyStimulus(1);
    checkOutput("t1_code_addr_3", 32'(code_addr), 32'd3);
    checkOutput("t1_r2", 32'(dut.regs_q[2]), 32'd8);

    // Taken branch on r1==0 from address 1 to 5, one bubble.
    clearRom();
    rom[0] = encI(4'd1, 3'd1, 11'd0);
    rom[1] = encR(4'd5, 3'd1, 3'd1, 8'd4);
    rom[2] = encI(4'd1, 3'd5, 11'h077);
    rom[5] = encI(4'd1, 3'd6, 11'd9);
    resetCore();
    applyStimulus(2);
    checkOutput("t2_code_addr_br", 32'(code_addr), 32'd2);
    checkOutput("t2_retire_br", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t2_code_addr_tgt", 32'(code_addr), 32'd5);
    checkOutput("t2_bubble", 32'(retire), 32'd0);
    applyStimulus(2);
    checkOutput("t2_r6", 32'(dut.regs_q[6]), 32'd9);
    checkOutput("t2_r5_skipped", 32'(dut.regs_q[5]), 32'd0);

    // Store with three wait states.
    clearRom();
    rom[0] = encI(4'd1, 3'd3, 11'h155);
    rom[1] = encR(4'd4, 3'd3, 3'd0, 8'd7);
    rom[2] = encI(4'd1, 3'd4, 11'd1);
    resetCore();
    applyStimulus(2);
    checkOutput("t3_req_a", 32'(memory_req), 32'd1);
    checkOutput("t3_we_a", 32'(memory_write_enable), 32'd1);
    checkOutput("t3_addr_a", 32'(memory_addr), 32'd7);
    checkOutput("t3_in_a", 32'(memory_in), 32'h155);
    checkOutput("t3_code_addr_a", 32'(code_addr), 32'd2);
    checkOutput("t3_retire_a", 32'(retire), 32'd0);
    applyStimulus(1);
    checkOutput("t3_req_b", 32'(memory_req), 32'd1);
    checkOutput("t3_addr_b", 32'(memory_addr), 32'd7);
    checkOutput("t3_code_addr_b", 32'(code_addr), 32'd2);
    checkOutput("t3_retire_b", 32'(retire), 32'd0);
    applyStimulus(1);
    checkOutput("t3_req_c", 32'(memory_req), 32'd1);
    checkOutput("t3_code_addr_c", 32'(code_addr), 32'd2);
    checkOutput("t3_retire_c", 32'(retire), 32'd0);
    applyStimulus(1);
    memory_ready = 1'b1;
    #1;
    checkOutput("t3_req_d", 32'(memory_req), 32'd1);
    checkOutput("t3_in_d", 32'(memory_in), 32'h155);
    checkOutput("t3_code_addr_d", 32'(code_addr), 32'd2);
    checkOutput("t3_retire_d", 32'(retire), 32'd1);
    applyStimulus(1);
    memory_ready = 1'b0;
    checkOutput("t3_req_done", 32'(memory_req), 32'd0);
    checkOutput("t3_code_addr_adv", 32'(code_addr), 32'd3);
    applyStimulus(1);
    checkOutput("t3_r4_after", 32'(dut.regs_q[4]), 32'd1);
    checkOutput("t3_r3_kept", 32'(dut.regs_q[3]), 32'h155);

    // Load completing immediately.
    clearRom();
    rom[0] = encR(4'd3, 3'd4, 3'd0, 8'd2);
    resetCore();
    memory_out   = 18'h2ABCD;
    memory_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t4_req", 32'(memory_req), 32'd1);
    checkOutput("t4_we", 32'(memory_write_enable), 32'd0);
    checkOutput("t4_addr", 32'(memory_addr), 32'd2);
    checkOutput("t4_retire", 32'(retire), 32'd1);
    checkOutput("t4_code_addr_1", 32'(code_addr), 32'd1);
    applyStimulus(1);
    checkOutput("t4_code_addr_2", 32'(code_addr), 32'd2);
    checkOutput("t4_r4", 32'(dut.regs_q[4]), 32'h2ABCD);
    checkOutput("t4_req_off", 32'(memory_req), 32'd0);
    memory_ready = 1'b0;

    // CALL +10 from 3, RET at 13.
    clearRom();
    rom[3]  = encI(4'd7, 3'd0, 11'd10);
    rom[4]  = encI(4'd1, 3'd7, 11'h033);
    rom[13] = encR(4'd8, 3'd0, 3'd0, 8'd0);
    resetCore();
    applyStimulus(4);
    checkOutput("t5_code_addr_call", 32'(code_addr), 32'd4);
    checkOutput("t5_retire_call", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t5_code_addr_13", 32'(code_addr), 32'd13);
    checkOutput("t5_bubble_1", 32'(retire), 32'd0);
    checkOutput("t5_lr", 32'(dut.lr_q), 32'd4);
    applyStimulus(1);
    checkOutput("t5_code_addr_14", 32'(code_addr), 32'd14);
    checkOutput("t5_retire_ret", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t5_code_addr_ret", 32'(code_addr), 32'd4);
    checkOutput("t5_bubble_2", 32'(retire), 32'd0);
    applyStimulus(2);
    checkOutput("t5_r7", 32'(dut.regs_q[7]), 32'h33);

    // HALT at address 6.
    clearRom();
    rom[6] = encR(4'd9, 3'd0, 3'd0, 8'd0);
    resetCore();
    applyStimulus(7);
    checkOutput("t6_retire_halt", 32'(retire), 32'd1);
    checkOutput("t6_halted_pre", 32'(halted), 32'd0);
    checkOutput("t6_code_addr_pre", 32'(code_addr), 32'd7);
    applyStimulus(1);
    checkOutput("t6_halted", 32'(halted), 32'd1);
    checkOutput("t6_code_addr_halt", 32'(code_addr), 32'd7);
    checkOutput("t6_retire_off", 32'(retire), 32'd0);
    applyStimulus(3);
    checkOutput("t6_code_addr_frozen", 32'(code_addr), 32'd7);
    checkOutput("t6_halted_held", 32'(halted), 32'd1);
    checkOutput("t6_retire_frozen", 32'(retire), 32'd0);

    // Reset asserted in the middle of a load stall.
    clearRom();
    rom[0] = encR(4'd3, 3'd1, 3'd0, 8'd5);
    resetCore();
    checkOutput("t6_halted_cleared", 32'(halted), 32'd0);
    applyStimulus(1);
    checkOutput("t6_stall_req", 32'(memory_req), 32'd1);
    checkOutput("t6_stall_code_addr", 32'(code_addr), 32'd1);
    checkOutput("t6_stall_retire", 32'(retire), 32'd0);
    applyStimulus(1);
    checkOutput("t6_stall_req_2", 32'(memory_req), 32'd1);
    checkOutput("t6_stall_code_addr_2", 32'(code_addr), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_req", 32'(memory_req), 32'd0);
    checkOutput("t6_rst_code_addr", 32'(code_addr), 32'd0);
    checkOutput("t6_rst_retire", 32'(retire), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Signed conditions, ALU register ops and shifted immediate.
    clearRom();
    rom[0] = encI(4'd1, 3'd1, 11'h7FD);
    rom[1] = encI(4'd1, 3'd2, 11'd5);
    rom[2] = encR(4'd6, 3'd2, 3'd1, 8'h00);
    rom[3] = encR(4'd5, 3'd1, 3'd3, 8'd2);
    rom[4] = encI(4'd1, 3'd5, 11'd1);
    rom[5] = encR(4'd5, 3'd2, 3'd6, 8'd8);
    rom[6] = encI(4'd2, 3'd6, 11'd3);
    rom[7] = encR(4'd6, 3'd6, 3'd2, 8'h01);
    resetCore();
    applyStimulus(4);
    checkOutput("t7_r1_neg", 32'(dut.regs_q[1]), 32'h3FFFD);
    checkOutput("t7_r2_add", 32'(dut.regs_q[2]), 32'd2);
    checkOutput("t7_code_addr_br", 32'(code_addr), 32'd4);
    applyStimulus(1);
    checkOutput("t7_code_addr_lt", 32'(code_addr), 32'd5);
    checkOutput("t7_bubble", 32'(retire), 32'd0);
    applyStimulus(1);
    checkOutput("t7_code_addr_6", 32'(code_addr), 32'd6);
    checkOutput("t7_retire_le", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t7_untaken_seq", 32'(code_addr), 32'd7);
    checkOutput("t7_untaken_retire", 32'(retire), 32'd1);
    applyStimulus(1);
    checkOutput("t7_r6_lui", 32'(dut.regs_q[6]), 32'h180);
    applyStimulus(1);
    checkOutput("t7_r6_sub", 32'(dut.regs_q[6]), 32'h17E);
    checkOutput("t7_r5_skipped", 32'(dut.regs_q[5]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
